sevenseg_scan: RTL and testbench

Multiplexed display scan controller that sits directly upstream of the sevenseg decoder. It holds a DIGITS-wide hex value and time-multiplexes one nibble at a time onto the decoder's 4-bit input, driving the matching active-low digit anode. It provides tear-free value updates at frame boundaries and optional leading-zero blanking.

---
 rtl/sevenseg_scan.sv | 114 +++++++++++
 tb/tb_sevenseg_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Multiplexed hex display scan controller feeding a seven-segment decoder.
// Values are double-buffered so the visible value only changes on a frame boundary.
module sevenseg_scan #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [3:0]            digit_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  busy_pending
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [3:0]            digit_out_q, digit_out_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  boundary;
    logic [DIGITS:0]       zero_from;
    logic [3:0]            nibble;
    logic                  blanked;

    always_comb begin
        tick        = (prescaler_q == PRE_LAST);
        boundary    = tick && (idx_q == IDX_LAST);
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        frame_done_d = boundary;
    end

    // A load coinciding with the boundary bypasses the pending buffer entirely.
    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (load) begin
            pend_d = value;
        end
        if (boundary && load) begin
            disp_d      = value;
            pend_flag_d = 1'b0;
        end else if (boundary && pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_flag_d = 1'b1;
        end
    end

    // zero_from[i] is set when digits DIGITS-1..i of the displayed value are all zero.
    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_q[4*i +: 4] == 4'h0);
        end
        nibble  = 4'h0;
        blanked = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nibble  = disp_q[4*i +: 4];
                blanked = blank_lz && (i > 0) && zero_from[i];
            end
        end
        an_d        = blanked ? '1 : ~(DIGITS'(1) << idx_q);
        digit_out_d = blanked ? 4'h0 : nibble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            digit_out_q  <= 4'h0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            digit_out_q  <= digit_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_out    = digit_out_q;
    assign an           = an_q;
    assign frame_done   = frame_done_q;
    assign busy_pending = pend_flag_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed plus random checks of sevenseg_scan against an arithmetic scan model,
// using a 4-digit/div-4 instance and a 2-digit/div-2 instance in parallel.
module tb_sevenseg_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic        frame_done;
    logic        busy_pending;

    logic [7:0]  value2;
    logic        load2;
    logic [3:0]  digit_out2;
    logic [1:0]  an2;
    logic        frame_done2;
    logic        busy_pending2;

    int total = 0;
    int bad   = 0;

    // model state: edges since reset, displayed/pending value, pending flag
    int edges;
    int m_disp,  m_pend;
    bit m_pf;
    int m2_disp, m2_pend;
    bit m2_pf;

    sevenseg_scan #(.DIGITS(4), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .digit_out(digit_out), .an(an), .frame_done(frame_done), .busy_pending(busy_pending)
    );

    sevenseg_scan #(.DIGITS(2), .CLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .value(value2), .load(load2), .blank_lz(1'b0),
        .digit_out(digit_out2), .an(an2), .frame_done(frame_done2), .busy_pending(busy_pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected registered outputs after the edge that follows e earlier edges.
    function automatic void scan_expect(input int d, input int c, input int e, input int disp,
                                        input bit blz, output int exp_an, output int exp_dig,
                                        output bit exp_fd);
        int  idx;
        bit  blank;
        idx     = (e / c) % d;
        blank   = blz && (idx > 0) && ((disp >> (4 * idx)) == 0);
        exp_an  = blank ? ((1 << d) - 1) : (((1 << d) - 1) ^ (1 << idx));
        exp_dig = blank ? 0 : ((disp >> (4 * idx)) & 15);
        exp_fd  = ((e + 1) % (c * d)) == 0;
    endfunction

    function automatic void buf_update(input bit ld, input int v, input bit bnd,
                                       inout int disp, inout int pend, inout bit pf);
        if (ld && bnd) begin
            disp = v; pend = v; pf = 1'b0;
        end else if (bnd && pf) begin
            disp = pend; pf = 1'b0;
            if (ld) begin pend = v; pf = 1'b1; end
        end else if (ld) begin
            pend = v; pf = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input bit ld2, input logic [7:0] v2);
        int ea, ed, ea2, ed2;
        bit ef, ef2;
        load   = ld;
        value  = v;
        load2  = ld2;
        value2 = v2;
        scan_expect(4, 4, edges, m_disp, blank_lz, ea, ed, ef);
        scan_expect(2, 2, edges, m2_disp, 1'b0, ea2, ed2, ef2);
        buf_update(ld, int'(v), ef, m_disp, m_pend, m_pf);
        buf_update(ld2, int'(v2), ef2, m2_disp, m2_pend, m2_pf);
        edges++;
        @(posedge clk);
        #1;
        chk("an",           int'(an),           ea);
        chk("digit_out",    int'(digit_out),    ed);
        chk("frame_done",   int'(frame_done),   int'(ef));
        chk("busy_pending", int'(busy_pending), int'(m_pf));
        chk("an2",          int'(an2),          ea2);
        chk("digit_out2",   int'(digit_out2),   ed2);
        chk("frame_done2",  int'(frame_done2),  int'(ef2));
        chk("an2_onehot",   int'($countones(~an2) <= 1), 1);
        @(negedge clk);
        load  = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic model_reset();
        edges = 0;
        m_disp = 0;  m_pend = 0;  m_pf = 1'b0;
        m2_disp = 0; m2_pend = 0; m2_pf = 1'b0;
    endtask

    task automatic idle_until_boundary_next();
        while (((edges + 1) % 16) != 0) step(1'b0, 16'h0, 1'b0, 8'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        value2   = '0;
        load2    = 1'b0;
        model_reset();
        #12;
        chk("rst_an",        int'(an),           4'hF);
        chk("rst_digit_out", int'(digit_out),    0);
        chk("rst_frame",     int'(frame_done),   0);
        chk("rst_busy",      int'(busy_pending), 0);
        chk("rst_an2",       int'(an2),          2'h3);
        @(negedge clk);
        rst_n = 1'b1;

        // basic scan: first frame shows zero, then 1234 for two frames
        step(1'b1, 16'h1234, 1'b1, 8'h3C);
        repeat (47) step(1'b0, 16'h0, 1'b0, 8'h0);

        // mid-frame load of ABCD, takes effect at the next boundary
        repeat (5) step(1'b0, 16'h0, 1'b0, 8'h0);
        step(1'b1, 16'hABCD, 1'b1, 8'hA5);
        repeat (26) step(1'b0, 16'h0, 1'b0, 8'h0);

        // 1111 then 2222 in one frame, 5555 exactly on the boundary
        step(1'b1, 16'h1111, 1'b0, 8'h0);
        repeat (3) step(1'b0, 16'h0, 1'b0, 8'h0);
        step(1'b1, 16'h2222, 1'b0, 8'h0);
        idle_until_boundary_next();
        step(1'b1, 16'h5555, 1'b0, 8'h0);
        repeat (18) step(1'b0, 16'h0, 1'b0, 8'h0);

        // leading-zero blanking
        blank_lz = 1'b1;
        step(1'b1, 16'h0040, 1'b0, 8'h0);
        idle_until_boundary_next();
        repeat (17) step(1'b0, 16'h0, 1'b0, 8'h0);
        step(1'b1, 16'h0000, 1'b0, 8'h0);
        idle_until_boundary_next();
        repeat (17) step(1'b0, 16'h0, 1'b0, 8'h0);
        blank_lz = 1'b0;

        // asynchronous reset mid-frame while a load is pending
        step(1'b1, 16'h9876, 1'b0, 8'h0);
        while (((edges / 4) % 4) != 3) step(1'b0, 16'h0, 1'b0, 8'h0);
        step(1'b1, 16'h4321, 1'b1, 8'h77);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an",        int'(an),           4'hF);
        chk("arst_digit_out", int'(digit_out),    0);
        chk("arst_busy",      int'(busy_pending), 0);
        chk("arst_frame",     int'(frame_done),   0);
        chk("arst_busy2",     int'(busy_pending2), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step(1'b0, 16'h0, 1'b0, 8'h0);

        // random loads, values and blanking
        for (int n = 0; n < 400; n++) begin
            if ((n % 23) == 0) blank_lz = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 7) == 0),
                 (($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom)),
                 ($urandom_range(0, 5) == 0),
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
